// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, cache access-type codes and master FSM state type.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Mirrors the cache's access-type encoding
  localparam logic [2:0] CACHE_BYTE      = 3'b000;
  localparam logic [2:0] CACHE_HWORD     = 3'b001;
  localparam logic [2:0] CACHE_WORD      = 3'b010;
  localparam logic [2:0] CACHE_BYTE_U    = 3'b100;
  localparam logic [2:0] CACHE_HWORD_U   = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StAww,
    StB,
    StDrain
  } axi_mst_state_e;

endpackage

// File: rtl/axi_wstrb_gen.sv
// Byte-lane strobe from cache access type and low address bits.
module axi_wstrb_gen
  import axi_pkg::*;
(
  input  logic [2:0] acc_type,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  always_comb begin
    wstrb = 4'h0;
    case (acc_type)
      CACHE_BYTE, CACHE_BYTE_U:   wstrb = 4'b0001 << addr_lo;
      CACHE_HWORD, CACHE_HWORD_U: wstrb = 4'b0011 << {addr_lo[1], 1'b0};
      CACHE_WORD:                 wstrb = 4'hF;
      default:                    wstrb = 4'h0;
    endcase
  end

endmodule

// File: rtl/l1d_axi_master.sv
// L1 data cache memory port: one word request at a time as a single-beat AXI4 transaction.
module l1d_axi_master
  import axi_pkg::*;
#(
  parameter logic [3:0]  AXI_ID = 4'd1,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              D_req,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic              D_write,
  input  logic [DATA_W-1:0] D_in,
  input  logic [2:0]        D_type,
  output logic [DATA_W-1:0] D_out,
  output logic              D_wait,
  output logic              bus_err,
  output logic [3:0]        ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [3:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [3:0]        RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [3:0]        AWID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [3:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [3:0]        WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [3:0]        BID,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY
);

  axi_mst_state_e    state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        type_q;
  logic              write_q;
  logic              arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic              aw_done_q, w_done_q;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs, aww_both;
  logic r_complete, b_complete;
  logic unused_in;

  assign ar_hs    = arvalid_q & ARREADY;
  assign r_hs     = rready_q & RVALID;
  assign aw_hs    = awvalid_q & AWREADY;
  assign w_hs     = wvalid_q & WREADY;
  assign b_hs     = bready_q & BVALID;
  assign aww_both = write_q & (aw_done_q | aw_hs) & (w_done_q | w_hs);

  // A response only completes the request if the cache is still asking for it
  assign r_complete = (state_q == StR) & r_hs & D_req;
  assign b_complete = (state_q == StB) & b_hs & D_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      data_q    <= '0;
      type_q    <= '0;
      write_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (state_q == StIdle) begin
      if (D_req) begin
        addr_q  <= D_addr;
        data_q  <= D_in;
        type_q  <= D_type;
        write_q <= D_write;
        if (D_write) begin
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          state_q   <= StAww;
        end else begin
          arvalid_q <= 1'b1;
          state_q   <= StAr;
        end
      end
    end else begin
      // Channel progress is identical whether the request is live or being drained
      if (ar_hs) begin
        arvalid_q <= 1'b0;
        rready_q  <= 1'b1;
      end
      if (r_hs) rready_q <= 1'b0;
      if (aw_hs) begin
        awvalid_q <= 1'b0;
        aw_done_q <= 1'b1;
      end
      if (w_hs) begin
        wvalid_q <= 1'b0;
        w_done_q <= 1'b1;
      end
      if (aww_both) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        bready_q  <= 1'b1;
      end
      if (b_hs) bready_q <= 1'b0;

      if (r_hs || b_hs)                      state_q <= StIdle;
      else if (!D_req)                       state_q <= StDrain;
      else if (state_q == StAr && ar_hs)     state_q <= StR;
      else if (state_q == StAww && aww_both) state_q <= StB;
    end
  end

  axi_wstrb_gen u_wstrb (
    .acc_type (type_q),
    .addr_lo  (addr_q[1:0]),
    .wstrb    (WSTRB)
  );

  assign D_wait  = ((state_q != StIdle) | D_req) & ~(r_complete | b_complete);
  assign D_out   = r_complete ? RDATA : '0;
  assign bus_err = (r_complete & (RRESP != AXI_RESP_OKAY)) |
                   (b_complete & (BRESP != AXI_RESP_OKAY));

  assign ARID    = AXI_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = 4'd0;
  assign ARSIZE  = AXI_SIZE_WORD;
  assign ARBURST = AXI_BURST_INCR;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;

  assign AWID    = AXI_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = 4'd0;
  assign AWSIZE  = AXI_SIZE_WORD;
  assign AWBURST = AXI_BURST_INCR;
  assign AWVALID = awvalid_q;
  assign WDATA   = data_q;
  assign WLAST   = 1'b1;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;

  // IDs and RLAST are deliberately not checked
  assign unused_in = ^{RID, RLAST, BID};

endmodule

// File: tb/tb_l1d_axi_master.sv
// Directed bench for l1d_axi_master: vector tables for reads/stores plus abandon and reset cases.
module tb_l1d_axi_master;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        D_req, D_write, D_wait, bus_err;
  logic [31:0] D_addr, D_in, D_out;
  logic [2:0]  D_type;
  logic [3:0]  ARID, ARLEN, AWID, AWLEN, RID, BID, WSTRB;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

  int n_pass  = 0;
  int n_total = 0;
  int dp      = 0;

  always #5 clk = ~clk;

  l1d_axi_master #(.AXI_ID(4'd1), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .D_req(D_req), .D_addr(D_addr), .D_write(D_write), .D_in(D_in), .D_type(D_type),
    .D_out(D_out), .D_wait(D_wait), .bus_err(bus_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          ar_lat;
    int          r_lat;
    logic [1:0]  resp;
    logic        err;
  } rd_vec_t;

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  strb;
    int          aw_lat;
    int          w_lat;
    int          b_lat;
    logic [1:0]  resp;
    logic        err;
  } wr_vec_t;

  rd_vec_t rv[7];
  wr_vec_t wv[7];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, want %b", name, act, exp);
  endtask

  task automatic run_read(input rd_vec_t v);
    bit hs;
    D_req = 1'b1; D_write = 1'b0; D_addr = v.addr; D_type = CACHE_WORD; D_in = '0;
    #1;
    chk1("rd_cap_wait", D_wait, 1'b1);
    chk1("rd_cap_arvalid", ARVALID, 1'b0);
    @(posedge clk); #1;
    hs = 1'b0;
    for (int n = 0; n < 16 && !hs; n++) begin
      ARREADY = (n >= v.ar_lat); #1;
      chk1("rd_arvalid", ARVALID, 1'b1);
      chk1("rd_ar_wait", D_wait, 1'b1);
      if (n == 0) begin
        chk32("rd_araddr", ARADDR, v.addr);
        chk32("rd_ar_fixed", 32'({ARID, ARLEN, ARSIZE, ARBURST}),
              32'({4'd1, 4'd0, 3'b010, 2'b01}));
      end
      hs = ARREADY;
      @(posedge clk); #1;
    end
    ARREADY = 1'b0;
    chk1("rd_ar_hs", hs, 1'b1);
    hs = 1'b0;
    for (int n = 0; n < 16 && !hs; n++) begin
      RVALID = (n >= v.r_lat); RDATA = v.data; RRESP = v.resp; #1;
      chk1("rd_rready", RREADY, 1'b1);
      if (D_wait == 1'b0) dp++;
      if (RVALID) begin
        chk1("rd_done_wait", D_wait, 1'b0);
        chk32("rd_dout", D_out, v.data);
        chk1("rd_bus_err", bus_err, v.err);
        hs = 1'b1;
      end else begin
        chk1("rd_busy_wait", D_wait, 1'b1);
      end
      @(posedge clk); #1;
    end
    RVALID = 1'b0; RRESP = AXI_RESP_OKAY;
    chk1("rd_r_hs", hs, 1'b1);
  endtask

  task automatic run_write(input wr_vec_t v);
    bit awd, wd, hs;
    D_req = 1'b1; D_write = 1'b1; D_addr = v.addr; D_type = v.typ; D_in = v.din;
    #1;
    chk1("wr_cap_wait", D_wait, 1'b1);
    chk1("wr_cap_awvalid", AWVALID, 1'b0);
    chk1("wr_cap_wvalid", WVALID, 1'b0);
    @(posedge clk); #1;
    awd = 1'b0; wd = 1'b0;
    for (int n = 0; n < 16 && !(awd && wd); n++) begin
      AWREADY = (n >= v.aw_lat); WREADY = (n >= v.w_lat); #1;
      chk1("wr_awvalid", AWVALID, !awd);
      chk1("wr_wvalid", WVALID, !wd);
      chk1("wr_aww_wait", D_wait, 1'b1);
      if (n == 0) begin
        chk32("wr_awaddr", AWADDR, v.addr);
        chk32("wr_wdata", WDATA, v.din);
        chk32("wr_wstrb", 32'(WSTRB), 32'(v.strb));
        chk32("wr_fixed", 32'({AWID, AWLEN, AWSIZE, AWBURST, WLAST}),
              32'({4'd1, 4'd0, 3'b010, 2'b01, 1'b1}));
      end
      if (AWREADY) awd = 1'b1;
      if (WREADY) wd = 1'b1;
      @(posedge clk); #1;
    end
    AWREADY = 1'b0; WREADY = 1'b0;
    chk1("wr_aww_done", awd & wd, 1'b1);
    hs = 1'b0;
    for (int n = 0; n < 16 && !hs; n++) begin
      BVALID = (n >= v.b_lat); BRESP = v.resp; #1;
      chk1("wr_bready", BREADY, 1'b1);
      chk1("wr_b_awvalid", AWVALID, 1'b0);
      if (BVALID) begin
        chk1("wr_done_wait", D_wait, 1'b0);
        chk1("wr_bus_err", bus_err, v.err);
        hs = 1'b1;
      end else begin
        chk1("wr_busy_wait", D_wait, 1'b1);
      end
      @(posedge clk); #1;
    end
    BVALID = 1'b0; BRESP = AXI_RESP_OKAY;
    chk1("wr_b_hs", hs, 1'b1);
  endtask

  initial begin
    D_req = 0; D_write = 0; D_addr = '0; D_in = '0; D_type = '0;
    ARREADY = 0; RID = 4'd1; RDATA = '0; RRESP = '0; RLAST = 1; RVALID = 0;
    AWREADY = 0; WREADY = 0; BID = 4'd1; BRESP = '0; BVALID = 0;

    rv[0] = '{32'h1000_0004, 32'hDEAD_BEEF, 0, 0, AXI_RESP_OKAY,   1'b0};
    rv[1] = '{32'h0000_0020, 32'h1111_0020, 2, 0, AXI_RESP_OKAY,   1'b0};
    rv[2] = '{32'h0000_0024, 32'h2222_0024, 2, 0, AXI_RESP_OKAY,   1'b0};
    rv[3] = '{32'h0000_0028, 32'h3333_0028, 2, 0, AXI_RESP_OKAY,   1'b0};
    rv[4] = '{32'h0000_002C, 32'h4444_002C, 2, 0, AXI_RESP_OKAY,   1'b0};
    rv[5] = '{32'h0000_0040, 32'hCAFE_F00D, 0, 3, AXI_RESP_EXOKAY, 1'b1};
    rv[6] = '{32'h0000_0044, 32'h1234_5678, 1, 1, AXI_RESP_DECERR, 1'b1};

    wv[0] = '{CACHE_BYTE,    32'h0000_0103, 32'hAB00_0000, 4'b1000, 3, 0, 0,
              AXI_RESP_OKAY, 1'b0};
    wv[1] = '{CACHE_HWORD,   32'h0000_0102, 32'hBEEF_0000, 4'b1100, 0, 0, 0,
              AXI_RESP_OKAY, 1'b0};
    wv[2] = '{CACHE_WORD,    32'h0000_0200, 32'h0102_0304, 4'b1111, 1, 2, 2,
              AXI_RESP_OKAY, 1'b0};
    wv[3] = '{CACHE_BYTE_U,  32'h0000_0101, 32'h0000_5A00, 4'b0010, 0, 1, 1,
              AXI_RESP_OKAY, 1'b0};
    wv[4] = '{CACHE_HWORD_U, 32'h0000_0100, 32'h0000_7788, 4'b0011, 2, 2, 0,
              AXI_RESP_OKAY, 1'b0};
    wv[5] = '{3'b011,        32'h0000_0104, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0,
              AXI_RESP_OKAY, 1'b0};
    wv[6] = '{CACHE_WORD,    32'h0000_0300, 32'h0BAD_0BAD, 4'b1111, 0, 0, 1,
              AXI_RESP_SLVERR, 1'b1};

    #10;
    chk1("rst_arvalid", ARVALID, 1'b0);
    chk1("rst_awvalid", AWVALID, 1'b0);
    chk1("rst_wvalid", WVALID, 1'b0);
    chk1("rst_rready", RREADY, 1'b0);
    chk1("rst_bready", BREADY, 1'b0);
    chk1("rst_dwait", D_wait, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk32("rst_dout", D_out, 32'h0);
    chk32("rst_araddr", ARADDR, 32'h0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back reads with D_req held throughout
    dp = 0;
    for (int i = 0; i < 7; i++) run_read(rv[i]);
    D_req = 1'b0; #1;
    chk1("rd_idle_wait", D_wait, 1'b0);
    chk32("rd_pulse_count", 32'(dp), 32'd7);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_write(wv[i]);
    D_req = 1'b0; #1;
    chk1("wr_err_one_cycle", bus_err, 1'b0);
    chk1("wr_idle_wait", D_wait, 1'b0);
    @(posedge clk); #1;

    // Abandon a read while in R; the late response is swallowed
    D_req = 1'b1; D_write = 1'b0; D_addr = 32'h0000_0080; D_type = CACHE_WORD;
    ARREADY = 1'b1; #1;
    @(posedge clk); #1;
    chk1("ab_arvalid", ARVALID, 1'b1);
    @(posedge clk); #1;
    ARREADY = 1'b0; D_req = 1'b0; #1;
    chk1("ab_rready_r", RREADY, 1'b1);
    chk1("ab_wait_r", D_wait, 1'b1);
    @(posedge clk); #1;
    for (int n = 1; n <= 4; n++) begin
      D_req = 1'b1; D_addr = 32'h0000_0300;
      RVALID = (n == 4); RDATA = 32'h5555_AAAA; RRESP = AXI_RESP_SLVERR; #1;
      chk1("ab_rready_drain", RREADY, 1'b1);
      chk1("ab_wait_drain", D_wait, 1'b1);
      chk1("ab_no_bus_err", bus_err, 1'b0);
      chk1("ab_no_new_ar", ARVALID, 1'b0);
      @(posedge clk); #1;
    end
    RVALID = 1'b0; RRESP = AXI_RESP_OKAY; #1;
    chk1("ab_rready_off", RREADY, 1'b0);
    chk1("ab_cap_wait", D_wait, 1'b1);
    chk1("ab_cap_arvalid", ARVALID, 1'b0);
    @(posedge clk); #1;
    chk1("ab_new_arvalid", ARVALID, 1'b1);
    chk32("ab_new_araddr", ARADDR, 32'h0000_0300);

    // Asynchronous reset while in AR
    D_req = 1'b0; rst = 1'b1; #1;
    chk1("rst_ar_arvalid", ARVALID, 1'b0);
    chk1("rst_ar_rready", RREADY, 1'b0);
    chk1("rst_ar_wait", D_wait, 1'b0);
    chk32("rst_ar_dout", D_out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk1("post_rst_idle", ARVALID, 1'b0);
    dp = 0;
    run_read(rv[0]);
    D_req = 1'b0; #1;
    chk32("post_rst_pulses", 32'(dp), 32'd1);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
